seq_mag_comparator: RTL
=======================

// Module: seq_mag_comparator
// PURPOSE
//  Multi-cycle magnitude comparator. Compares two WIDTH-bit operands one SLICE-bit slice per cycle,
//  MSB slice first, and exits as soon as a slice differs. Signed or unsigned mode is selected per
//  transaction. Valid/ready on both sides; sits between operand producers and datapath control.
//  Generalises the 1-bit lt/gt/eq comparator in width, signedness and handshake.
// PARAMETERS
//  WIDTH      32  operand width in bits; must be a multiple of SLICE
//  SLICE       8  bits compared per cycle; NSLICES = WIDTH/SLICE, must be >= 1
//  SIGNED_EN   1  1: is_signed honoured; 0: is_signed ignored, always unsigned
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A, captured on accept
//  b          in   WIDTH  operand B, captured on accept
//  is_signed  in   1      two's-complement compare, captured on accept
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  lt         out  1      A < B
//  gt         out  1      A > B
//  eq         out  1      A == B
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, lt=gt=eq=0, slice index=0. rst overrides all inputs.
//  - FSM IDLE -> CMP -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid&&in_ready at edge T: latch a, b, is_signed (forced 0 if
//    SIGNED_EN=0); clear lt/gt/eq; idx=0; go to CMP.
//  - CMP: in_ready=0. Compare slice NSLICES-1-idx of A and B.
//    - Slice differs: register lt/gt from that slice and go to DONE.
//    - Slice equal and idx==NSLICES-1: register eq=1 and go to DONE.
//    - Slice equal otherwise: idx++ and stay in CMP.
//  - Signed rule: applies to the MSB slice (idx=0) with signed mode active. If the sign bits
//    differ, the operand with sign=1 is smaller. Otherwise the unsigned slice compare stands.
//    Lower slices are always compared unsigned.
//  - Latency: with k = 1 + index of the first differing slice (k = NSLICES if all equal),
//    out_valid rises after edge T+k. Range 1..NSLICES cycles.
//  - DONE: out_valid=1; lt/gt/eq stable and exactly one is high. Outputs hold while
//    out_ready=0 (no time-out). On out_valid&&out_ready: go to IDLE, out_valid=0, in_ready=1 on
//    the next cycle. lt/gt/eq keep their last value until the next accept.
//  - No overlap: no new accept in the same cycle as result handoff; throughput is one
//    transaction per k+2 cycles at most.
//  - in_valid/a/b changes outside IDLE are ignored, because the operands are latched.
//  - rst in CMP or DONE: abandon the transaction with no result emitted; next cycle is the
//    reset state.
//  - All outputs are registered except in_ready, which is decoded from state.
// STRUCTURE
//  - Package cmp_pkg:
//    - state enum {IDLE, CMP, DONE} as 2-bit localparams
//    - function nslices(WIDTH, SLICE)
//    - function clog2 for the idx width
//  - Sub-module cmp_slice #(SLICE): combinational SLICE-bit lt/gt/eq, plus a msb_signed input
//    implementing the sign rule. It is instantiated once, on the slice muxed by idx.
//  - Top holds the FSM, operand registers, idx counter and result registers.
//  - Elaboration check: WIDTH % SLICE == 0.
// TESTING (WIDTH=32, SLICE=8)
//  1. Unsigned 0x12345678 vs 0x12345678 -> out_valid after T+4; eq=1, lt=gt=0.
//  2. 0x80000000 vs 0x7FFFFFFF: unsigned -> gt=1 at T+1; signed -> lt=1 at T+1.
//  3. Unsigned 0x12340000 vs 0x12350000 -> lt=1 at T+2 (early exit on slice 2).
//  4. Signed 0xFFFFFFFF vs 0xFFFFFFFE -> gt=1 at T+4.
//     Signed 0x00000000 vs 0xFFFFFFFF -> gt=1 at T+1.
//  5. Hold out_ready=0 for 5 cycles after a result -> result stable and in_ready=0 throughout.
//     Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
//  6. Pulse rst at T+2 of case 1 -> next cycle in_ready=1, out_valid=0, lt=gt=eq=0, and no
//     result appears. Then run case 3 and check it is correct.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the elaboration-time helpers that size the slice index.
package cmp_pkg;

  // State encodings, kept as plain constants so checkers can match on them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CMP  = ST_CMP,
    DONE = ST_DONE
  } state_e;

  // Result bundle as it appears on the output side.
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_res_t;

  // Number of slices the operand splits into.
  function automatic int nslices(input int width, input int slice);
    return width / slice;
  endfunction

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index register width; never narrower than one bit so a single-slice
  // configuration still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage : cmp_pkg

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit comparator. When msb_signed is set the top bit of
// the slice is treated as the two's-complement sign of the whole operand.
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             msb_signed_i,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o
);

  logic sign_differs;

  assign sign_differs = a_i[SLICE-1] ^ b_i[SLICE-1];

  // Sign rule first (negative operand is smaller), otherwise unsigned compare.
  always_comb begin
    lt_o = 1'b0;
    gt_o = 1'b0;
    eq_o = 1'b0;
    if (msb_signed_i && sign_differs) begin
      lt_o = a_i[SLICE-1];
      gt_o = b_i[SLICE-1];
    end else begin
      lt_o = (a_i <  b_i);
      gt_o = (a_i >  b_i);
      eq_o = (a_i == b_i);
    end
  end

endmodule : cmp_slice

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one slice per cycle,
// MSB slice first, and stops at the first slice that differs.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds its payload until that edge, and
// ready may depend on state only. On the input side in_ready is high only in
// IDLE; on the output side out_valid is high only in DONE and the result
// holds until out_ready is seen.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SLICE     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [1:0]       dbg_state_o
);

  localparam int NSLICES = nslices(WIDTH, SLICE);
  localparam int IDXW    = idx_width(NSLICES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  // Reject configurations the slice walk cannot handle.
  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("seq_mag_comparator: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e                              state_q;
  logic   [IDXW-1:0]                   idx_q;
  logic   [NSLICES-1:0][SLICE-1:0]     a_q;
  logic   [NSLICES-1:0][SLICE-1:0]     b_q;
  logic                                signed_q;
  logic                                out_valid_q;
  cmp_res_t                            res_q;

  logic   [IDXW-1:0]                   sel_d;
  logic   [SLICE-1:0]                  a_sl_d;
  logic   [SLICE-1:0]                  b_sl_d;
  logic                                msb_signed_d;
  logic                                sl_lt;
  logic                                sl_gt;
  logic                                sl_eq;

  // Select the slice under comparison: idx 0 is the most significant slice.
  always_comb begin
    sel_d        = LAST_IDX - idx_q;
    a_sl_d       = a_q[sel_d];
    b_sl_d       = b_q[sel_d];
    msb_signed_d = signed_q && (idx_q == '0);
  end

  cmp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i          (a_sl_d),
    .b_i          (b_sl_d),
    .msb_signed_i (msb_signed_d),
    .lt_o         (sl_lt),
    .gt_o         (sl_gt),
    .eq_o         (sl_eq)
  );

  // FSM, operand capture, slice index and registered result in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= SIGNED_EN ? is_signed : 1'b0;
            res_q    <= '0;
            idx_q    <= '0;
            state_q  <= CMP;
          end
        end
        CMP: begin
          if (!sl_eq) begin
            res_q       <= '{lt: sl_lt, gt: sl_gt, eq: 1'b0};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == LAST_IDX) begin
            res_q       <= '{lt: 1'b0, gt: 1'b0, eq: 1'b1};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // Result stays up for as long as the consumer stalls.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is the only output decoded straight from state.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign lt          = res_q.lt;
  assign gt          = res_q.gt;
  assign eq          = res_q.eq;
  assign dbg_state_o = state_q;

endmodule : seq_mag_comparator
